// File: rtl/sha_sched_pkg.sv
// Shared types and helpers for the SHA core-pool scheduler.
package sha_sched_pkg;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    HOLD  = 2'd3
  } coreState_t;

  // Index width that never collapses to zero for single-entry pools.
  function automatic int idxW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sha_pool_scheduler_if.sv
// Request, core-control and completion signals between requesters, core pool and scheduler.
interface sha_pool_scheduler_if
  import sha_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_CORES = 2,
  parameter int TAG_W     = 4
) ();

  localparam int REQ_W  = idxW(NUM_REQ);
  localparam int CORE_W = idxW(NUM_CORES);
  localparam int CNT_W  = idxW(NUM_CORES + 1);

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0][TAG_W-1:0]     req_tag;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_CORES-1:0]              core_start;
  logic [NUM_CORES-1:0][REQ_W-1:0]   core_owner;
  logic [NUM_CORES-1:0]              core_done;
  logic                              rsp_valid;
  logic                              rsp_ready;
  logic [REQ_W-1:0]                  rsp_req;
  logic [TAG_W-1:0]                  rsp_tag;
  logic [CORE_W-1:0]                 rsp_core;
  logic [CNT_W-1:0]                  busy_cnt;
  logic                              err;

  modport master (
    output req_valid, req_tag, core_done, rsp_ready,
    input  req_ready, core_start, core_owner, rsp_valid, rsp_req, rsp_tag, rsp_core,
           busy_cnt, err
  );

  modport slave (
    input  req_valid, req_tag, core_done, rsp_ready,
    output req_ready, core_start, core_owner, rsp_valid, rsp_req, rsp_tag, rsp_core,
           busy_cnt, err
  );

endinterface

// File: rtl/sha_pool_scheduler_rr_arbiter.sv
// Round-robin requester arbiter; the search starts one past the last granted requester.
module rr_arbiter
  import sha_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic                       i_enable,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [idxW(NUM_REQ)-1:0]   o_grantIdx,
  output logic                       o_grantValid
);

  localparam int IDX_W = idxW(NUM_REQ);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_found && i_req[j]) begin
        w_found = 1'b1;
        w_idx   = IDX_W'(j);
      end
    end
    o_grantValid = w_found & i_enable;
    o_grantIdx   = w_idx;
    o_grant      = '0;
    if (o_grantValid) o_grant[w_idx] = 1'b1;
  end

  // Pointer only moves on an actual grant, so a stalled pool keeps fairness order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (o_grantValid) begin
      r_ptr <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/sha_pool_scheduler.sv
// Dispatches hash jobs from several requesters onto a shared pool of SHA cores
// and returns completions in core-index order.
module sha_pool_scheduler
  import sha_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_CORES = 2,
  parameter int TAG_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  sha_pool_scheduler_if.slave  bus
);

  localparam int REQ_W  = idxW(NUM_REQ);
  localparam int CORE_W = idxW(NUM_CORES);
  localparam int CNT_W  = idxW(NUM_CORES + 1);

  coreState_t          r_state     [NUM_CORES];
  coreState_t          w_nextState [NUM_CORES];
  logic [REQ_W-1:0]    r_owner     [NUM_CORES];
  logic [TAG_W-1:0]    r_tag       [NUM_CORES];
  logic                r_err;
  logic                r_rspHeld;
  logic [CORE_W-1:0]   r_rspSel;

  logic                w_freeAny;
  logic [CORE_W-1:0]   w_freeIdx;
  logic                w_holdAny;
  logic [CORE_W-1:0]   w_holdIdx;
  logic [CORE_W-1:0]   w_rspSel;
  logic                w_rspFire;
  logic                w_doneErr;
  logic [NUM_REQ-1:0]  w_grant;
  logic [REQ_W-1:0]    w_grantIdx;
  logic                w_grantValid;
  logic [CNT_W-1:0]    w_busyCnt;

  always_comb begin
    w_freeAny = 1'b0;
    w_freeIdx = '0;
    w_holdAny = 1'b0;
    w_holdIdx = '0;
    for (int c = NUM_CORES - 1; c >= 0; c--) begin
      if (r_state[c] == FREE) begin
        w_freeAny = 1'b1;
        w_freeIdx = CORE_W'(c);
      end
      if (r_state[c] == HOLD) begin
        w_holdAny = 1'b1;
        w_holdIdx = CORE_W'(c);
      end
    end
  end

  // A presented response stays locked even if a lower core reaches HOLD meanwhile.
  assign w_rspSel  = r_rspHeld ? r_rspSel : w_holdIdx;
  assign w_rspFire = w_holdAny & bus.rsp_ready;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arbiter (
    .clk          (clk),
    .reset        (reset),
    .i_req        (bus.req_valid),
    .i_enable     (w_freeAny),
    .o_grant      (w_grant),
    .o_grantIdx   (w_grantIdx),
    .o_grantValid (w_grantValid)
  );

  assign bus.req_ready = w_grant;

  always_comb begin
    w_doneErr = 1'b0;
    for (int c = 0; c < NUM_CORES; c++) begin
      w_nextState[c] = r_state[c];
      unique case (r_state[c])
        FREE:  if (w_grantValid && (w_freeIdx == CORE_W'(c))) w_nextState[c] = START;
        START: w_nextState[c] = BUSY;
        BUSY:  if (bus.core_done[c]) w_nextState[c] = HOLD;
        HOLD:  if (w_rspFire && (w_rspSel == CORE_W'(c))) w_nextState[c] = FREE;
        default: w_nextState[c] = FREE;
      endcase
      if (bus.core_done[c] && (r_state[c] != BUSY)) w_doneErr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        r_state[c] <= FREE;
        r_owner[c] <= '0;
        r_tag[c]   <= '0;
      end
      r_err     <= 1'b0;
      r_rspHeld <= 1'b0;
      r_rspSel  <= '0;
    end else begin
      for (int c = 0; c < NUM_CORES; c++) begin
        r_state[c] <= w_nextState[c];
      end
      if (w_grantValid) begin
        r_owner[w_freeIdx] <= w_grantIdx;
        r_tag[w_freeIdx]   <= bus.req_tag[w_grantIdx];
      end
      if (w_doneErr) r_err <= 1'b1;
      if (w_holdAny && !bus.rsp_ready) begin
        r_rspHeld <= 1'b1;
        r_rspSel  <= w_rspSel;
      end else begin
        r_rspHeld <= 1'b0;
      end
    end
  end

  always_comb begin
    w_busyCnt = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (r_state[c] != FREE) w_busyCnt = w_busyCnt + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    assign bus.core_start[g] = (r_state[g] == START);
    assign bus.core_owner[g] = r_owner[g];
  end

  assign bus.rsp_valid = w_holdAny;
  assign bus.rsp_core  = w_holdAny ? w_rspSel : '0;
  assign bus.rsp_req   = w_holdAny ? r_owner[w_rspSel] : '0;
  assign bus.rsp_tag   = w_holdAny ? r_tag[w_rspSel] : '0;
  assign bus.busy_cnt  = w_busyCnt;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_sha_pool_scheduler.sv
// Directed bench for sha_pool_scheduler: inputs change just after posedge, outputs sampled at negedge.
module tb_sha_pool_scheduler;

  logic clk;
  logic reset;
  int   nChecks;
  int   nFails;

  sha_pool_scheduler_if #(.NUM_REQ(4), .NUM_CORES(2), .TAG_W(4)) bus ();

  sha_pool_scheduler #(.NUM_REQ(4), .NUM_CORES(2), .TAG_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic applyReset();
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_tag   = '0;
    bus.core_done = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    applyReset();
    mid();
    nChecks++; if (bus.req_ready !== 4'b0000) begin nFails++; $display("[TB] FAIL reset_req_ready: got %b expected %b", bus.req_ready, 4'b0000); end
    nChecks++; if (bus.core_start !== 2'b00) begin nFails++; $display("[TB] FAIL reset_core_start: got %b expected %b", bus.core_start, 2'b00); end
    nChecks++; if (bus.core_owner !== 4'h0) begin nFails++; $display("[TB] FAIL reset_core_owner: got %h expected %h", bus.core_owner, 4'h0); end
    nChecks++; if (bus.rsp_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_rsp_valid: got %b expected %b", bus.rsp_valid, 1'b0); end
    nChecks++; if (bus.busy_cnt !== 2'd0) begin nFails++; $display("[TB] FAIL reset_busy_cnt: got %0d expected %0d", bus.busy_cnt, 0); end
    nChecks++; if (bus.err !== 1'b0) begin nFails++; $display("[TB] FAIL reset_err: got %b expected %b", bus.err, 1'b0); end
  endtask

  task automatic test_basic();
    applyReset();
    bus.req_valid  = 4'b0001;
    bus.req_tag[0] = 4'd3;
    mid();
    nChecks++; if (bus.req_ready !== 4'b0001) begin nFails++; $display("[TB] FAIL basic_grant: got %b expected %b", bus.req_ready, 4'b0001); end
    tick();
    bus.req_valid = '0;
    mid();
    nChecks++; if (bus.core_start !== 2'b01) begin nFails++; $display("[TB] FAIL basic_start: got %b expected %b", bus.core_start, 2'b01); end
    nChecks++; if (bus.core_owner[0] !== 2'd0) begin nFails++; $display("[TB] FAIL basic_owner: got %0d expected %0d", bus.core_owner[0], 0); end
    nChecks++; if (bus.busy_cnt !== 2'd1) begin nFails++; $display("[TB] FAIL basic_busy: got %0d expected %0d", bus.busy_cnt, 1); end
    tick();
    bus.core_done = 2'b01;
    mid();
    nChecks++; if (bus.core_start !== 2'b00) begin nFails++; $display("[TB] FAIL basic_start_pulse: got %b expected %b", bus.core_start, 2'b00); end
    tick();
    bus.core_done = 2'b00;
    mid();
    nChecks++; if (bus.rsp_valid !== 1'b1) begin nFails++; $display("[TB] FAIL basic_rsp_valid: got %b expected %b", bus.rsp_valid, 1'b1); end
    nChecks++; if (bus.rsp_req !== 2'd0) begin nFails++; $display("[TB] FAIL basic_rsp_req: got %0d expected %0d", bus.rsp_req, 0); end
    nChecks++; if (bus.rsp_tag !== 4'd3) begin nFails++; $display("[TB] FAIL basic_rsp_tag: got %0d expected %0d", bus.rsp_tag, 3); end
    nChecks++; if (bus.rsp_core !== 1'b0) begin nFails++; $display("[TB] FAIL basic_rsp_core: got %0d expected %0d", bus.rsp_core, 0); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    mid();
    nChecks++; if (bus.rsp_valid !== 1'b0) begin nFails++; $display("[TB] FAIL basic_rsp_drop: got %b expected %b", bus.rsp_valid, 1'b0); end
    nChecks++; if (bus.busy_cnt !== 2'd0) begin nFails++; $display("[TB] FAIL basic_busy_free: got %0d expected %0d", bus.busy_cnt, 0); end
  endtask

  task automatic test_fill();
    applyReset();
    bus.req_tag[0] = 4'd1;
    bus.req_tag[1] = 4'd2;
    bus.req_tag[2] = 4'd5;
    bus.req_tag[3] = 4'd9;
    bus.req_valid  = 4'b1111;
    mid();
    nChecks++; if (bus.req_ready !== 4'b0001) begin nFails++; $display("[TB] FAIL fill_grant_r0: got %b expected %b", bus.req_ready, 4'b0001); end
    tick();
    mid();
    nChecks++; if (bus.req_ready !== 4'b0010) begin nFails++; $display("[TB] FAIL fill_grant_r1: got %b expected %b", bus.req_ready, 4'b0010); end
    tick();
    mid();
    nChecks++; if (bus.req_ready !== 4'b0000) begin nFails++; $display("[TB] FAIL fill_stall: got %b expected %b", bus.req_ready, 4'b0000); end
    nChecks++; if (bus.busy_cnt !== 2'd2) begin nFails++; $display("[TB] FAIL fill_busy_peak: got %0d expected %0d", bus.busy_cnt, 2); end
    tick();
    bus.core_done = 2'b10;
    mid();
    nChecks++; if (bus.req_ready !== 4'b0000) begin nFails++; $display("[TB] FAIL fill_stall2: got %b expected %b", bus.req_ready, 4'b0000); end
    tick();
    bus.core_done = 2'b00;
    mid();
    nChecks++; if (bus.rsp_core !== 1'b1) begin nFails++; $display("[TB] FAIL fill_rsp1_core: got %0d expected %0d", bus.rsp_core, 1); end
    nChecks++; if (bus.rsp_req !== 2'd1) begin nFails++; $display("[TB] FAIL fill_rsp1_req: got %0d expected %0d", bus.rsp_req, 1); end
    nChecks++; if (bus.rsp_tag !== 4'd2) begin nFails++; $display("[TB] FAIL fill_rsp1_tag: got %0d expected %0d", bus.rsp_tag, 2); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    mid();
    nChecks++; if (bus.req_ready !== 4'b0100) begin nFails++; $display("[TB] FAIL fill_grant_r2: got %b expected %b", bus.req_ready, 4'b0100); end
    tick();
    mid();
    nChecks++; if (bus.core_owner[1] !== 2'd2) begin nFails++; $display("[TB] FAIL fill_owner_r2: got %0d expected %0d", bus.core_owner[1], 2); end
    nChecks++; if (bus.core_start !== 2'b10) begin nFails++; $display("[TB] FAIL fill_start_c1: got %b expected %b", bus.core_start, 2'b10); end
    tick();
    bus.core_done = 2'b01;
    tick();
    bus.core_done = 2'b00;
    mid();
    nChecks++; if (bus.rsp_core !== 1'b0) begin nFails++; $display("[TB] FAIL fill_rsp0_core: got %0d expected %0d", bus.rsp_core, 0); end
    nChecks++; if (bus.rsp_tag !== 4'd1) begin nFails++; $display("[TB] FAIL fill_rsp0_tag: got %0d expected %0d", bus.rsp_tag, 1); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    mid();
    nChecks++; if (bus.req_ready !== 4'b1000) begin nFails++; $display("[TB] FAIL fill_grant_r3: got %b expected %b", bus.req_ready, 4'b1000); end
    tick();
    bus.req_valid = '0;
    mid();
    nChecks++; if (bus.core_owner[0] !== 2'd3) begin nFails++; $display("[TB] FAIL fill_owner_r3: got %0d expected %0d", bus.core_owner[0], 3); end
  endtask

  task automatic test_simul_done();
    applyReset();
    bus.req_tag[0] = 4'hA;
    bus.req_tag[1] = 4'hB;
    bus.req_valid  = 4'b0011;
    tick();
    tick();
    bus.req_valid = '0;
    tick();
    bus.core_done = 2'b11;
    tick();
    bus.core_done = 2'b00;
    for (int i = 0; i < 3; i++) begin
      mid();
      nChecks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_core !== 1'b0) begin nFails++; $display("[TB] FAIL simul_hold_stable: got valid=%b core=%0d expected valid=1 core=0", bus.rsp_valid, bus.rsp_core); end
      tick();
    end
    bus.rsp_ready = 1'b1;
    mid();
    nChecks++; if (bus.rsp_tag !== 4'hA) begin nFails++; $display("[TB] FAIL simul_rsp0_tag: got %h expected %h", bus.rsp_tag, 4'hA); end
    nChecks++; if (bus.err !== 1'b0) begin nFails++; $display("[TB] FAIL simul_no_err: got %b expected %b", bus.err, 1'b0); end
    tick();
    mid();
    nChecks++; if (bus.rsp_core !== 1'b1) begin nFails++; $display("[TB] FAIL simul_rsp1_core: got %0d expected %0d", bus.rsp_core, 1); end
    nChecks++; if (bus.rsp_req !== 2'd1) begin nFails++; $display("[TB] FAIL simul_rsp1_req: got %0d expected %0d", bus.rsp_req, 1); end
    nChecks++; if (bus.rsp_tag !== 4'hB) begin nFails++; $display("[TB] FAIL simul_rsp1_tag: got %h expected %h", bus.rsp_tag, 4'hB); end
    tick();
    bus.rsp_ready = 1'b0;
    mid();
    nChecks++; if (bus.rsp_valid !== 1'b0) begin nFails++; $display("[TB] FAIL simul_drained: got %b expected %b", bus.rsp_valid, 1'b0); end
    nChecks++; if (bus.busy_cnt !== 2'd0) begin nFails++; $display("[TB] FAIL simul_busy: got %0d expected %0d", bus.busy_cnt, 0); end
  endtask

  task automatic test_no_regrant();
    applyReset();
    bus.req_valid = 4'b0011;
    tick();
    tick();
    bus.req_valid = '0;
    tick();
    bus.core_done = 2'b01;
    tick();
    bus.core_done = 2'b00;
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b1;
    mid();
    nChecks++; if (bus.rsp_valid !== 1'b1) begin nFails++; $display("[TB] FAIL noregrant_rsp: got %b expected %b", bus.rsp_valid, 1'b1); end
    nChecks++; if (bus.req_ready !== 4'b0000) begin nFails++; $display("[TB] FAIL noregrant_hs_cycle: got %b expected %b", bus.req_ready, 4'b0000); end
    tick();
    bus.rsp_ready = 1'b0;
    mid();
    nChecks++; if (bus.req_ready !== 4'b0010) begin nFails++; $display("[TB] FAIL noregrant_next: got %b expected %b", bus.req_ready, 4'b0010); end
    tick();
    bus.req_valid = '0;
    mid();
    nChecks++; if (bus.core_start !== 2'b01) begin nFails++; $display("[TB] FAIL noregrant_start: got %b expected %b", bus.core_start, 2'b01); end
    nChecks++; if (bus.core_owner[0] !== 2'd1) begin nFails++; $display("[TB] FAIL noregrant_owner: got %0d expected %0d", bus.core_owner[0], 1); end
  endtask

  task automatic test_err();
    applyReset();
    bus.core_done = 2'b10;
    tick();
    bus.core_done = 2'b00;
    mid();
    nChecks++; if (bus.err !== 1'b1) begin nFails++; $display("[TB] FAIL err_set: got %b expected %b", bus.err, 1'b1); end
    nChecks++; if (bus.busy_cnt !== 2'd0) begin nFails++; $display("[TB] FAIL err_state: got %0d expected %0d", bus.busy_cnt, 0); end
    nChecks++; if (bus.rsp_valid !== 1'b0) begin nFails++; $display("[TB] FAIL err_no_rsp: got %b expected %b", bus.rsp_valid, 1'b0); end
    tick();
    tick();
    mid();
    nChecks++; if (bus.err !== 1'b1) begin nFails++; $display("[TB] FAIL err_sticky: got %b expected %b", bus.err, 1'b1); end
    applyReset();
    mid();
    nChecks++; if (bus.err !== 1'b0) begin nFails++; $display("[TB] FAIL err_clear: got %b expected %b", bus.err, 1'b0); end
  endtask

  task automatic test_reset_mid();
    applyReset();
    bus.req_valid = 4'b0011;
    tick();
    tick();
    bus.req_valid = '0;
    tick();
    mid();
    nChecks++; if (bus.busy_cnt !== 2'd2) begin nFails++; $display("[TB] FAIL rstmid_busy_before: got %0d expected %0d", bus.busy_cnt, 2); end
    reset = 1'b1;
    tick();
    mid();
    nChecks++; if (bus.busy_cnt !== 2'd0) begin nFails++; $display("[TB] FAIL rstmid_busy_after: got %0d expected %0d", bus.busy_cnt, 0); end
    nChecks++; if (bus.rsp_valid !== 1'b0) begin nFails++; $display("[TB] FAIL rstmid_no_rsp: got %b expected %b", bus.rsp_valid, 1'b0); end
    reset = 1'b0;
    bus.core_done = 2'b11;
    tick();
    bus.core_done = 2'b00;
    mid();
    nChecks++; if (bus.err !== 1'b1) begin nFails++; $display("[TB] FAIL rstmid_stale_err: got %b expected %b", bus.err, 1'b1); end
    nChecks++; if (bus.rsp_valid !== 1'b0) begin nFails++; $display("[TB] FAIL rstmid_stale_rsp: got %b expected %b", bus.rsp_valid, 1'b0); end
    nChecks++; if (bus.busy_cnt !== 2'd0) begin nFails++; $display("[TB] FAIL rstmid_stale_busy: got %0d expected %0d", bus.busy_cnt, 0); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nChecks = 0;
    nFails  = 0;
    reset   = 1'b1;
    test_reset();
    test_basic();
    test_fill();
    test_simul_done();
    test_no_regrant();
    test_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
